// File: rtl/bomb_timer_ctrl.sv
// Countdown sequencer for the bomb game: gates the 1 s tick generator, counts
// remaining time down, applies strike penalties and resolves exploded/defused.
module bomb_timer_ctrl #(
    parameter int START_MIN   = 5,
    parameter int START_SEC   = 0,
    parameter int PENALTY_SEC = 10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       pause,
    input  logic       strike,
    input  logic       defuse,
    input  logic       uno_second,
    output logic       timer_en,
    output logic [3:0] min_tens,
    output logic [3:0] min_ones,
    output logic [3:0] sec_tens,
    output logic [3:0] sec_ones,
    output logic [2:0] state,
    output logic       exploded,
    output logic       defused
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_RUNNING  = 3'd1,
        S_PAUSED   = 3'd2,
        S_EXPLODED = 3'd3,
        S_DEFUSED  = 3'd4
    } state_t;

    localparam logic [12:0] LOAD_T = 13'(START_MIN * 60 + START_SEC);
    localparam logic [12:0] PEN_T  = 13'(PENALTY_SEC);
    localparam logic [3:0]  RST_MT = 4'(START_MIN / 10);
    localparam logic [3:0]  RST_MO = 4'(START_MIN % 10);
    localparam logic [3:0]  RST_ST = 4'(START_SEC / 10);
    localparam logic [3:0]  RST_SO = 4'(START_SEC % 10);

    state_t      state_q, state_d;
    logic [12:0] time_q, time_d;
    logic        timer_en_q, timer_en_d;
    logic        exploded_q, exploded_d;
    logic        defused_q, defused_d;
    logic [3:0]  min_tens_q, min_tens_d;
    logic [3:0]  min_ones_q, min_ones_d;
    logic [3:0]  sec_tens_q, sec_tens_d;
    logic [3:0]  sec_ones_q, sec_ones_d;

    logic [12:0] dec, rem;
    logic [6:0]  mins;
    logic [5:0]  secs;

    always_comb begin
        state_d = state_q;
        time_d  = time_q;
        dec     = '0;
        rem     = '0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    time_d  = LOAD_T;
                    state_d = (LOAD_T == 13'd0) ? S_EXPLODED : S_RUNNING;
                end
            end
            S_RUNNING, S_PAUSED: begin
                // Strike and tick in one cycle combine into a single saturating subtract.
                dec = (strike ? PEN_T : 13'd0) +
                      ((uno_second && state_q == S_RUNNING) ? 13'd1 : 13'd0);
                rem = (time_q > dec) ? time_q - dec : 13'd0;
                if (defuse) begin
                    state_d = S_DEFUSED;
                end else if (dec != 13'd0 && rem == 13'd0) begin
                    time_d  = 13'd0;
                    state_d = S_EXPLODED;
                end else begin
                    time_d = rem;
                    if (state_q == S_RUNNING && pause)
                        state_d = S_PAUSED;
                    else if (state_q == S_PAUSED && start)
                        state_d = S_RUNNING;
                end
            end
            S_EXPLODED: time_d = 13'd0;
            S_DEFUSED:  ;
            default: begin
                state_d = S_IDLE;
                time_d  = LOAD_T;
            end
        endcase
    end

    // Digits are converted from the next count so they land on the same edge.
    always_comb begin
        mins       = 7'(time_d / 13'd60);
        secs       = 6'(time_d % 13'd60);
        min_tens_d = 4'(mins / 7'd10);
        min_ones_d = 4'(mins % 7'd10);
        sec_tens_d = 4'(secs / 6'd10);
        sec_ones_d = 4'(secs % 6'd10);
        timer_en_d = (state_d == S_RUNNING);
        exploded_d = (state_d == S_EXPLODED);
        defused_d  = (state_d == S_DEFUSED);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            time_q     <= LOAD_T;
            timer_en_q <= 1'b0;
            exploded_q <= 1'b0;
            defused_q  <= 1'b0;
            min_tens_q <= RST_MT;
            min_ones_q <= RST_MO;
            sec_tens_q <= RST_ST;
            sec_ones_q <= RST_SO;
        end else begin
            state_q    <= state_d;
            time_q     <= time_d;
            timer_en_q <= timer_en_d;
            exploded_q <= exploded_d;
            defused_q  <= defused_d;
            min_tens_q <= min_tens_d;
            min_ones_q <= min_ones_d;
            sec_tens_q <= sec_tens_d;
            sec_ones_q <= sec_ones_d;
        end
    end

    assign state    = state_q;
    assign timer_en = timer_en_q;
    assign exploded = exploded_q;
    assign defused  = defused_q;
    assign min_tens = min_tens_q;
    assign min_ones = min_ones_q;
    assign sec_tens = sec_tens_q;
    assign sec_ones = sec_ones_q;

endmodule

// File: tb/tb_bomb_timer_ctrl.sv
// Directed bench for bomb_timer_ctrl with default parameters (05:00 load, 10 s penalty).
module tb_bomb_timer_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0, pause = 1'b0, strike = 1'b0, defuse = 1'b0, uno_second = 1'b0;
    logic       timer_en, exploded, defused;
    logic [3:0] min_tens, min_ones, sec_tens, sec_ones;
    logic [2:0] state;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    bomb_timer_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .pause      (pause),
        .strike     (strike),
        .defuse     (defuse),
        .uno_second (uno_second),
        .timer_en   (timer_en),
        .min_tens   (min_tens),
        .min_ones   (min_ones),
        .sec_tens   (sec_tens),
        .sec_ones   (sec_ones),
        .state      (state),
        .exploded   (exploded),
        .defused    (defused)
    );

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_time(input string tag, input int m, input int s);
        logic [15:0] e;
        e = {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
        chk(tag, {min_tens, min_ones, sec_tens, sec_ones}, e);
    endtask

    // Packs {state, timer_en, exploded, defused}.
    task automatic chk_st(input string tag, input logic [2:0] st, input logic en,
                          input logic ex, input logic df);
        chk(tag, {10'd0, state, timer_en, exploded, defused}, {10'd0, st, en, ex, df});
    endtask

    task automatic step(input logic st, input logic pa, input logic sk,
                        input logic df, input logic un);
        start = st; pause = pa; strike = sk; defuse = df; uno_second = un;
        @(posedge clk); #1;
        start = 0; pause = 0; strike = 0; defuse = 0; uno_second = 0;
    endtask

    task automatic ticks(input int n);
        repeat (n) step(0, 0, 0, 0, 1);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
    endtask

    initial begin
        // Reset and arm
        repeat (2) @(posedge clk);
        #1;
        chk_st("rst_state", 3'd0, 0, 0, 0);
        chk_time("rst_time", 5, 0);
        rst = 1'b1;
        step(0, 1, 1, 1, 1);
        chk_st("idle_ignore_st", 3'd0, 0, 0, 0);
        chk_time("idle_ignore_t", 5, 0);
        step(1, 0, 0, 0, 0);
        chk_st("arm_st", 3'd1, 1, 0, 0);
        chk_time("arm_t", 5, 0);

        // Borrow
        ticks(1);
        chk_time("borrow_459", 4, 59);
        ticks(59);
        chk_time("borrow_400", 4, 0);
        ticks(30);
        chk_time("t_330", 3, 30);

        // Pause with same-cycle tick, then frozen
        step(0, 1, 0, 0, 1);
        chk_st("pause_st", 3'd2, 0, 0, 0);
        chk_time("pause_tick", 3, 29);
        ticks(3);
        chk_time("paused_frozen", 3, 29);
        chk_st("paused_st", 3'd2, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        chk_st("resume_st", 3'd1, 1, 0, 0);
        ticks(1);
        chk_time("resume_tick", 3, 28);

        // Strike while paused still costs time
        step(0, 1, 0, 0, 0);
        step(0, 0, 1, 0, 0);
        chk_time("paused_strike", 3, 18);
        chk_st("paused_strike_st", 3'd2, 0, 0, 0);
        step(1, 0, 0, 0, 0);

        // Penalty
        ticks(183);
        chk_time("t_015", 0, 15);
        step(0, 0, 1, 0, 0);
        chk_time("strike_005", 0, 5);
        chk_st("strike_005_st", 3'd1, 1, 0, 0);
        step(0, 1, 0, 0, 0);
        step(0, 0, 1, 0, 0);
        chk_time("paused_sat", 0, 0);
        chk_st("paused_sat_st", 3'd3, 0, 1, 0);
        step(1, 0, 0, 1, 1);
        chk_st("expl_terminal", 3'd3, 0, 1, 0);
        chk_time("expl_terminal_t", 0, 0);

        // Collision, then defuse priority over an expiring tick
        do_reset();
        chk_st("rst2_st", 3'd0, 0, 0, 0);
        chk_time("rst2_t", 5, 0);
        step(1, 0, 0, 0, 0);
        ticks(285);
        chk_time("t_015b", 0, 15);
        step(0, 0, 1, 0, 1);
        chk_time("collide_004", 0, 4);
        chk_st("collide_st", 3'd1, 1, 0, 0);
        ticks(3);
        chk_time("t_001", 0, 1);
        step(0, 0, 0, 1, 1);
        chk_st("defuse_st", 3'd4, 0, 0, 1);
        chk_time("defuse_hold", 0, 1);
        step(1, 1, 1, 0, 1);
        chk_st("defused_terminal", 3'd4, 0, 0, 1);
        chk_time("defused_terminal_t", 0, 1);

        // Asynchronous reset mid-state, checked before any clock edge
        rst = 1'b0;
        #1;
        chk_st("async_rst_st", 3'd0, 0, 0, 0);
        chk_time("async_rst_t", 5, 0);
        @(posedge clk); #1 rst = 1'b1;

        // Strike driving time to zero
        step(1, 0, 0, 0, 0);
        ticks(293);
        chk_time("t_007", 0, 7);
        step(0, 0, 1, 0, 0);
        chk_time("strike_zero", 0, 0);
        chk_st("strike_zero_st", 3'd3, 0, 1, 0);

        // Natural expiry
        do_reset();
        step(1, 0, 0, 0, 0);
        ticks(299);
        chk_time("t_001b", 0, 1);
        chk_st("t_001b_st", 3'd1, 1, 0, 0);
        ticks(1);
        chk_time("expire_t", 0, 0);
        chk_st("expire_st", 3'd3, 0, 1, 0);
        step(1, 0, 0, 1, 0);
        chk_st("expire_terminal", 3'd3, 0, 1, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
